// File: rtl/cti8_pkg.sv
// Shared types and constants for the CTI-8 arithmetic/logic stage.
package cti8_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_ADC    = 4'h1,
    OP_SUB    = 4'h2,
    OP_SBC    = 4'h3,
    OP_AND    = 4'h4,
    OP_OR     = 4'h5,
    OP_XOR    = 4'h6,
    OP_NOT    = 4'h7,
    OP_SHL    = 4'h8,
    OP_SHR    = 4'h9,
    OP_ROL    = 4'hA,
    OP_ROR    = 4'hB,
    OP_INC    = 4'hC,
    OP_DEC    = 4'hD,
    OP_MUL_LO = 4'hE,
    OP_MUL_HI = 4'hF
  } alu_op_t;

  localparam int unsigned FLAG_C = 32'd3;
  localparam int unsigned FLAG_Z = 32'd2;
  localparam int unsigned FLAG_N = 32'd1;
  localparam int unsigned FLAG_V = 32'd0;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_t;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == OP_MUL_LO) || (op == OP_MUL_HI);
  endfunction

  // Pack {C,Z,N,V} with Z and N derived from the written byte.
  function automatic logic [3:0] pack_flags(input logic c, input logic [7:0] r, input logic v);
    return {c, (r == 8'h00), r[7], v};
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU operations; the multiply opcodes are handled by alu_unit.
module alu_comb
  import cti8_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  alu_op_t    op,
  input  logic       cin,
  output logic [7:0] result,
  output logic       c,
  output logic       v
);

  logic       use_cin;
  logic [8:0] sum9;
  logic [8:0] diff9;
  logic [7:0] inc8;
  logic [7:0] dec8;

  // Shared 9-bit adder/subtractor; bit 8 of diff9 is the borrow.
  always_comb begin
    use_cin = (op == OP_ADC) || (op == OP_SBC);
    sum9    = {1'b0, a} + {1'b0, b} + {8'd0, use_cin & cin};
    diff9   = {1'b0, a} - {1'b0, b} - {8'd0, use_cin & cin};
    inc8    = a + 8'd1;
    dec8    = a - 8'd1;
  end

  // Result, carry and overflow selection; C passes through where the op leaves it alone.
  always_comb begin
    result = 8'h00;
    c      = cin;
    v      = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        result = sum9[7:0];
        c      = sum9[8];
        v      = (a[7] == b[7]) && (sum9[7] != a[7]);
      end
      OP_SUB, OP_SBC: begin
        result = diff9[7:0];
        c      = diff9[8];
        v      = (a[7] != b[7]) && (diff9[7] != a[7]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = {a[6:0], 1'b0};
        c      = a[7];
      end
      OP_SHR: begin
        result = {1'b0, a[7:1]};
        c      = a[0];
      end
      OP_ROL: begin
        result = {a[6:0], cin};
        c      = a[7];
      end
      OP_ROR: begin
        result = {cin, a[7:1]};
        c      = a[0];
      end
      OP_INC: begin
        result = inc8;
        v      = (a == 8'h7F);
      end
      OP_DEC: begin
        result = dec8;
        v      = (a == 8'h80);
      end
      default: begin
        result = 8'h00;
        c      = cin;
        v      = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_unit.sv
// CTI-8 ALU stage: single-cycle ops, 8-step shift-add multiply, result latch,
// flags register and tri-state bus driver.
module alu_unit
  import cti8_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] op,
  input  logic       start,
  input  logic       flags_wr,
  input  logic       oe,
  inout  wire  [7:0] dataBus,
  output logic [3:0] flags,
  output logic       busy
);

  alu_state_t  state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  mcand_q, mcand_d;
  logic [7:0]  mplier_q, mplier_d;
  logic        mul_hi_q, mul_hi_d;
  logic        mul_fw_q, mul_fw_d;
  logic [7:0]  result_q, result_d;
  logic [3:0]  flags_q, flags_d;
  logic        busy_q, busy_d;

  logic [7:0]  comb_res;
  logic        comb_c;
  logic        comb_v;
  logic [8:0]  mul_sum;
  logic [15:0] mul_acc;
  logic [7:0]  mul_byte;

  alu_comb u_alu_comb (
    .a      (a),
    .b      (b),
    .op     (alu_op_t'(op)),
    .cin    (flags_q[FLAG_C]),
    .result (comb_res),
    .c      (comb_c),
    .v      (comb_v)
  );

  // One multiply step: conditional add into the high half, then shift right.
  always_comb begin
    mul_sum  = {1'b0, acc_q[15:8]} + (mplier_q[0] ? {1'b0, mcand_q} : 9'd0);
    mul_acc  = {mul_sum, acc_q[7:1]};
    mul_byte = mul_hi_q ? mul_acc[15:8] : mul_acc[7:0];
  end

  // Next-state logic for the FSM, multiplier datapath, result latch and flags.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    mul_hi_d = mul_hi_q;
    mul_fw_d = mul_fw_q;
    result_d = result_q;
    flags_d  = flags_q;
    busy_d   = busy_q;
    if (clk_en) begin
      case (state_q)
        IDLE: begin
          if (start && is_mul_op(op)) begin
            state_d  = MUL;
            busy_d   = 1'b1;
            step_d   = 3'd0;
            acc_d    = 16'h0000;
            mcand_d  = a;
            mplier_d = b;
            mul_hi_d = (op == OP_MUL_HI);
            mul_fw_d = flags_wr;
          end else if (start) begin
            result_d = comb_res;
            flags_d  = flags_wr ? pack_flags(comb_c, comb_res, comb_v) : flags_q;
          end else begin
            state_d = IDLE;
          end
        end
        MUL: begin
          acc_d    = mul_acc;
          mplier_d = {1'b0, mplier_q[7:1]};
          step_d   = step_q + 3'd1;
          if (step_q == 3'd7) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            result_d = mul_byte;
            flags_d  = mul_fw_q ? pack_flags(|mul_acc[15:8], mul_byte, 1'b0) : flags_q;
          end else begin
            state_d = MUL;
          end
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      step_q   <= 3'd0;
      acc_q    <= 16'h0000;
      mcand_q  <= 8'h00;
      mplier_q <= 8'h00;
      mul_hi_q <= 1'b0;
      mul_fw_q <= 1'b0;
      result_q <= 8'h00;
      flags_q  <= 4'h0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      mul_hi_q <= mul_hi_d;
      mul_fw_q <= mul_fw_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      busy_q   <= busy_d;
    end
  end

  assign dataBus = oe ? result_q : 8'hzz;
  assign flags   = flags_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_alu_unit.sv
// Randomized self-checking bench for alu_unit against an arithmetic reference model.
module tb_alu_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_en;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] op;
  logic       start;
  logic       flags_wr;
  logic       oe;
  wire  [7:0] dataBus;
  logic [3:0] flags;
  logic       busy;
  logic       tb_drv;

  int         n_checks = 0;
  int         n_errors = 0;
  int         exp_res;
  logic [3:0] exp_flags;

  assign dataBus = tb_drv ? 8'h5A : 8'hzz;

  alu_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .a        (a),
    .b        (b),
    .op       (op),
    .start    (start),
    .flags_wr (flags_wr),
    .oe       (oe),
    .dataBus  (dataBus),
    .flags    (flags),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int to_signed8(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  // Returns {C,Z,N,V, result}, computed from the opcode rules with plain integers.
  function automatic logic [11:0] ref_model(input int opc, input int x, input int y, input logic [3:0] f);
    int c, r, s, sx, sy, cin, p;
    bit nc, nv;
    logic [3:0] nf;
    c  = int'(f[3]);
    nc = f[3];
    nv = 1'b0;
    sx = to_signed8(x);
    sy = to_signed8(y);
    cin = (opc == 1 || opc == 3) ? c : 0;
    p  = x * y;
    r  = 0;
    case (opc)
      0, 1: begin
        s = x + y + cin; r = s % 256; nc = (s > 255);
        s = sx + sy + cin; nv = (s > 127) || (s < -128);
      end
      2, 3: begin
        r = (x - y - cin + 512) % 256; nc = (x < y + cin);
        s = sx - sy - cin; nv = (s > 127) || (s < -128);
      end
      4: r = x & y;
      5: r = x | y;
      6: r = x ^ y;
      7: r = 255 - x;
      8: begin r = (x * 2) % 256; nc = (x >= 128); end
      9: begin r = x / 2; nc = (x % 2 == 1); end
      10: begin r = (x * 2) % 256 + c; nc = (x >= 128); end
      11: begin r = x / 2 + 128 * c; nc = (x % 2 == 1); end
      12: begin r = (x + 1) % 256; nv = (sx + 1 > 127); end
      13: begin r = (x + 255) % 256; nv = (sx - 1 < -128); end
      14: begin r = p % 256; nc = (p > 255); end
      15: begin r = p / 256; nc = (p > 255); end
      default: r = 0;
    endcase
    nf = {nc, (r == 0), (r >= 128), nv};
    return {nf, r[7:0]};
  endfunction

  // Launch one op, follow a multiply to completion, then check against the model.
  task automatic run_op(input int opc, input int x, input int y, input bit fw,
                        input bit gaps, input bit spam);
    logic [11:0] m;
    int old_res, en_cnt, cycles;
    old_res  = exp_res;
    m        = ref_model(opc, x, y, exp_flags);
    a        = x[7:0];
    b        = y[7:0];
    op       = opc[3:0];
    flags_wr = fw;
    start    = 1'b1;
    clk_en   = 1'b1;
    tick();
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    if (opc >= 14) begin
      check_eq("mul_busy_rise", 16'(busy), 16'd1);
      en_cnt = 0;
      cycles = 0;
      while (en_cnt < 8 && cycles < 64) begin
        clk_en = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (spam) begin
          start = 1'($urandom);
          op    = 4'h0;
        end
        tick();
        cycles++;
        if (clk_en) en_cnt++;
        if (en_cnt < 8) begin
          check_eq("mul_busy_hold", 16'(busy), 16'd1);
          check_eq("mul_old_bus", 16'(dataBus), 16'(old_res));
        end
      end
      if (en_cnt < 8) check_eq("mul_timeout", 16'(en_cnt), 16'd8);
      start  = 1'b0;
      clk_en = 1'b1;
    end
    exp_res = int'(m[7:0]);
    if (fw) exp_flags = m[11:8];
    check_eq("busy_idle", 16'(busy), 16'd0);
    check_eq("result", 16'(dataBus), 16'(exp_res));
    check_eq("flags", 16'(flags), 16'(exp_flags));
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b0; a = 8'h00; b = 8'h00; op = 4'h0;
    start = 1'b0; flags_wr = 1'b0; oe = 1'b1; tb_drv = 1'b0;
    exp_res = 0; exp_flags = 4'h0;
    #2;
    check_eq("rst_bus", 16'(dataBus), 16'h00);
    check_eq("rst_flags", 16'(flags), 16'h0);
    check_eq("rst_busy", 16'(busy), 16'd0);
    oe = 1'b0; tb_drv = 1'b1; #1;
    check_eq("oe_off_bus", 16'(dataBus), 16'h5A);
    tb_drv = 1'b0; oe = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    run_op(0, 8'h7F, 8'h01, 1'b1, 1'b0, 1'b0);
    check_eq("add_res", 16'(dataBus), 16'h80);
    check_eq("add_flags", 16'(flags), 16'b0011);
    run_op(2, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
    check_eq("sub_res", 16'(dataBus), 16'hFF);
    check_eq("sub_flags", 16'(flags), 16'b1010);
    run_op(1, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
    check_eq("adc_res", 16'(dataBus), 16'h00);
    check_eq("adc_flags", 16'(flags), 16'b1100);
    run_op(11, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
    check_eq("ror_res", 16'(dataBus), 16'h80);
    check_eq("ror_flags", 16'(flags), 16'b1010);
    run_op(14, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    check_eq("mullo_res", 16'(dataBus), 16'h01);
    check_eq("mullo_flags", 16'(flags), 16'b1000);
    run_op(15, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
    check_eq("mulhi_res", 16'(dataBus), 16'hFE);
    check_eq("mulhi_flags", 16'(flags), 16'b1010);
    run_op(0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check_eq("nofw_flags", 16'(flags), 16'b1010);

    // Start with clk_en low must be ignored.
    a = 8'h10; b = 8'h20; op = 4'h0; flags_wr = 1'b1; start = 1'b1; clk_en = 1'b0;
    tick();
    start = 1'b0; clk_en = 1'b1;
    check_eq("en_low_res", 16'(dataBus), 16'(exp_res));
    check_eq("en_low_flags", 16'(flags), 16'(exp_flags));

    // Reset in the middle of a multiply.
    a = 8'hFF; b = 8'hFF; op = 4'hF; flags_wr = 1'b1; start = 1'b1; clk_en = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("mid_busy", 16'(busy), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 16'(busy), 16'd0);
    check_eq("mid_rst_bus", 16'(dataBus), 16'h00);
    check_eq("mid_rst_flags", 16'(flags), 16'h0);
    exp_res = 0; exp_flags = 4'h0;
    tick();
    rst_n = 1'b1;
    tick();
    run_op(14, 8'h0F, 8'h11, 1'b1, 1'b1, 1'b0);
    check_eq("post_rst_mul", 16'(dataBus), 16'hFF);

    for (int n = 0; n < 300; n++) begin
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0),
             1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
